sha256_stream_padder: RTL and testbench

Sequential byte-stream front end for the SHA-256 datapath. Accepts a message one byte per cycle over a valid/ready handshake and emits 512-bit padded blocks (message bytes, 0x80 marker, zero fill, 64-bit big-endian bit length) over a second valid/ready handshake. It sits directly upstream of `sha256` and replaces the fixed-width combinational padder for messages of arbitrary length and more than one block.

---
 rtl/sha256_stream_padder.sv | 185 ++++++++++++++++++
 tb/tb_sha256_stream_padder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_padder.sv
// sha256_stream_padder
// Byte-stream front end for the SHA-256 datapath. Collects one message byte
// per cycle into a 64-byte buffer and presents padded 512-bit blocks
// (data, 0x80 marker, zero fill, big-endian bit length).
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   in_valid_i/in_ready_o   byte handshake; in_data_i byte, in_last_i final byte
//   blk_valid_o/blk_ready_i block handshake
//   blk_data_o              512-bit block, byte 0 at [511:504]
//   blk_first_o             first block of a message
//   blk_last_o              final block of a message (carries the length)
//   blk_count_o, msg_count_o  block / message handshake counters, present only
//                           when SHA256_PAD_STATS_EN is defined
module sha256_stream_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [7:0]   in_data_i,
    input  logic         in_last_i,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    output logic [511:0] blk_data_o,
    output logic         blk_first_o,
    output logic         blk_last_o
`ifdef SHA256_PAD_STATS_EN
    ,
    output logic [31:0]  blk_count_o,
    output logic [31:0]  msg_count_o
`endif
);

    localparam int CNT_W = LEN_W - 3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        EMIT_LEN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [511:0]       buf_q, buf_d;
    logic [5:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   bytecnt_q, bytecnt_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               pend_q, pend_d;   // length-only block still owed
    logic               mark_q, mark_d;   // length block carries 0x80 at byte 0
    logic               rdy_en_q;         // holds in_ready low until first edge after reset

    logic [CNT_W-1:0]   bytecnt_inc;
    logic [5:0]         nidx;
    logic [8:0]         data_off;
    logic [8:0]         mark_off;

    assign bytecnt_inc = bytecnt_q + CNT_ONE;
    assign nidx        = idx_q + 6'd1;
    // Byte k lives at bits [(63-k)*8 +: 8]; 63-k is the bitwise inverse for 6 bits.
    assign data_off    = {~idx_q, 3'b000};
    assign mark_off    = {~nidx, 3'b000};

    assign in_ready_o  = rdy_en_q && (state_q == FILL);
    assign blk_valid_o = (state_q == EMIT) || (state_q == EMIT_LEN);
    assign blk_data_o  = buf_q;
    assign blk_first_o = blk_valid_o && first_q;
    assign blk_last_o  = blk_valid_o && last_q;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        bytecnt_d = bytecnt_q;
        first_d   = first_q;
        last_d    = last_q;
        pend_d    = pend_q;
        mark_d    = mark_q;

        case (state_q)
            FILL: begin
                if (in_valid_i && rdy_en_q) begin
                    buf_d[data_off +: 8] = in_data_i;
                    idx_d     = nidx;
                    bytecnt_d = bytecnt_inc;
                    if (in_last_i) begin
                        // Bytes past idx are already zero (buffer cleared on
                        // every handshake), so only the marker is written.
                        if (idx_q != 6'd63) begin
                            buf_d[mark_off +: 8] = 8'h80;
                        end
                        if (idx_q <= 6'd54) begin
                            buf_d[LEN_W-1:0] = {bytecnt_inc, 3'b000};
                            last_d = 1'b1;
                            pend_d = 1'b0;
                        end else begin
                            last_d = 1'b0;
                            pend_d = 1'b1;
                            mark_d = (idx_q == 6'd63);
                        end
                        state_d = EMIT;
                    end else if (idx_q == 6'd63) begin
                        last_d  = 1'b0;
                        pend_d  = 1'b0;
                        state_d = EMIT;
                    end
                end
            end

            EMIT, EMIT_LEN: begin
                if (blk_ready_i) begin
                    buf_d = '0;
                    idx_d = '0;
                    if (last_q) begin
                        bytecnt_d = '0;
                        first_d   = 1'b1;
                        last_d    = 1'b0;
                        state_d   = FILL;
                    end else begin
                        first_d = 1'b0;
                        if (pend_q) begin
                            // bytecnt_q already holds the full message length.
                            buf_d[511:504]   = mark_q ? 8'h80 : 8'h00;
                            buf_d[LEN_W-1:0] = {bytecnt_q, 3'b000};
                            last_d  = 1'b1;
                            pend_d  = 1'b0;
                            mark_d  = 1'b0;
                            state_d = EMIT_LEN;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= FILL;
            buf_q     <= '0;
            idx_q     <= '0;
            bytecnt_q <= '0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            pend_q    <= 1'b0;
            mark_q    <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            bytecnt_q <= bytecnt_d;
            first_q   <= first_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            mark_q    <= mark_d;
            rdy_en_q  <= 1'b1;
        end
    end

`ifdef SHA256_PAD_STATS_EN
    logic [31:0] blk_count_q, msg_count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blk_count_q <= '0;
            msg_count_q <= '0;
        end else if (blk_valid_o && blk_ready_i) begin
            blk_count_q <= blk_count_q + 32'd1;
            if (last_q) begin
                msg_count_q <= msg_count_q + 32'd1;
            end
        end
    end

    assign blk_count_o = blk_count_q;
    assign msg_count_o = msg_count_q;
`endif

endmodule

// File: tb/tb_sha256_stream_padder.sv
module tb_sha256_stream_padder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_last;
    logic [7:0]   in_data;
    logic         blk_valid, blk_ready, blk_first, blk_last;
    logic [511:0] blk_data;
`ifdef SHA256_PAD_STATS_EN
    logic [31:0]  blk_count, msg_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int exp_blk  = 0;
    int exp_msg  = 0;

    always #5 clk = ~clk;

    sha256_stream_padder dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .blk_valid_o (blk_valid),
        .blk_ready_i (blk_ready),
        .blk_data_o  (blk_data),
        .blk_first_o (blk_first),
        .blk_last_o  (blk_last)
`ifdef SHA256_PAD_STATS_EN
        ,
        .blk_count_o (blk_count),
        .msg_count_o (msg_count)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole padded message as a byte array, then sliced into blocks.
    task automatic run_msg(input logic [7:0] msg[$], input int gap_pct, input int rdy_pct,
                           input int hold, input string name);
        logic [7:0]   pad[$];
        logic [63:0]  bitlen;
        logic [511:0] exp_blk_data, prev_data;
        int L, plen, nblk, sent, got, cyc, prev_hs;
        bit prev_hold, len_only;
        L      = msg.size();
        plen   = ((L + 8) / 64 + 1) * 64;
        nblk   = plen / 64;
        bitlen = 64'(L) * 64'd8;
        pad    = msg;
        pad.push_back(8'h80);
        while (pad.size() < plen - 8) pad.push_back(8'h00);
        for (int i = 0; i < 8; i++) pad.push_back(8'(bitlen >> (8 * (7 - i))));
        len_only  = ((L % 64) >= 56) || ((L % 64) == 0);
        sent = 0; got = 0; cyc = 0; prev_hs = -10; prev_hold = 0; prev_data = '0;

        while ((sent < L || got < nblk) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (prev_hold) begin
                chk({name, " hold_valid"}, 512'(blk_valid), 512'(1));
                chk({name, " hold_data"}, blk_data, prev_data);
            end
            if (blk_valid) chk({name, " in_ready_in_emit"}, 512'(in_ready), 512'(0));

            if (sent < L) begin
                in_valid = ($urandom_range(99) >= gap_pct);
                in_data  = msg[sent];
                in_last  = (sent == L - 1);
            end else begin
                // Junk offered while a block is pending must not be consumed.
                in_valid = blk_valid;
                in_data  = 8'hA5;
                in_last  = 1'b1;
            end
            if (hold > 0) begin
                blk_ready = 1'b0;
                if (blk_valid) hold--;
            end else begin
                blk_ready = ($urandom_range(99) < rdy_pct);
            end

            if (in_valid && in_ready && sent < L) sent++;
            if (blk_valid && blk_ready) begin
                if (got >= nblk) begin
                    chk({name, " extra_block"}, 512'(got), 512'(nblk - 1));
                end else begin
                    for (int b = 0; b < 64; b++) exp_blk_data[511 - 8*b -: 8] = pad[got*64 + b];
                    chk({name, " data"}, blk_data, exp_blk_data);
                    chk({name, " first"}, 512'(blk_first), 512'(got == 0));
                    chk({name, " last"}, 512'(blk_last), 512'(got == nblk - 1));
                    if (rdy_pct == 100 && len_only && got == nblk - 1)
                        chk({name, " len_blk_b2b"}, 512'(cyc), 512'(prev_hs + 1));
                end
                exp_blk++;
                if (got == nblk - 1) exp_msg++;
                prev_hs = cyc;
                got++;
            end
            prev_hold = blk_valid && !blk_ready;
            prev_data = blk_data;
        end
        chk({name, " bytes_consumed"}, 512'(sent), 512'(L));
        chk({name, " blocks_seen"}, 512'(got), 512'(nblk));
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
`ifdef SHA256_PAD_STATS_EN
        chk({name, " blk_count"}, 512'(blk_count), 512'(exp_blk));
        chk({name, " msg_count"}, 512'(msg_count), 512'(exp_msg));
`endif
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " in_ready"}, 512'(in_ready), 512'(0));
        chk({tag, " blk_valid"}, 512'(blk_valid), 512'(0));
        chk({tag, " blk_data"}, blk_data, 512'(0));
        chk({tag, " blk_first"}, 512'(blk_first), 512'(0));
        chk({tag, " blk_last"}, 512'(blk_last), 512'(0));
`ifdef SHA256_PAD_STATS_EN
        chk({tag, " blk_count"}, 512'(blk_count), 512'(0));
        chk({tag, " msg_count"}, 512'(msg_count), 512'(0));
`endif
    endtask

    initial begin
        logic [7:0] m[$];
        logic [511:0] abc_blk;

        // Reset state, with a byte offered that must not be taken.
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0; blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 512'(in_ready), 512'(1));
        exp_blk = 0; exp_msg = 0;

        // "abc": exact block from the known SHA-256 test vector.
        m = '{8'h61, 8'h62, 8'h63};
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[63:0]    = 64'h18;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h61; in_last = 1'b0; blk_ready = 1'b1;
        @(negedge clk); in_data = 8'h62;
        @(negedge clk); in_data = 8'h63; in_last = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        chk("abc valid", 512'(blk_valid), 512'(1));
        chk("abc data", blk_data, abc_blk);
        chk("abc first", 512'(blk_first), 512'(1));
        chk("abc last", 512'(blk_last), 512'(1));
        @(negedge clk);
        chk("abc done_valid", 512'(blk_valid), 512'(0));
        chk("abc done_ready", 512'(in_ready), 512'(1));
        blk_ready = 1'b0;
        exp_blk++; exp_msg++;

        // 56 zero bytes: marker block then length-only block back to back.
        m = {};
        repeat (56) m.push_back(8'h00);
        run_msg(m, 0, 100, 0, "zero56");
`ifdef SHA256_PAD_STATS_EN
        chk("stats abc+56 blk", 512'(blk_count), 512'(3));
        chk("stats abc+56 msg", 512'(msg_count), 512'(2));
`endif

        m = {};
        repeat (55) m.push_back(8'h00);
        run_msg(m, 0, 100, 0, "zero55");

        m = {};
        repeat (64) m.push_back(8'hFF);
        run_msg(m, 0, 100, 0, "ff64");

        // Backpressure: hold blk_ready low for 5 cycles on the abc block.
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 0, 100, 5, "abc_bp");

        // Reset mid-message, then abc must come out clean.
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1); in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_blk = 0; exp_msg = 0;
        @(negedge clk);
        run_msg(m, 0, 100, 0, "abc_after_reset");

        // Randomized lengths, data, input gaps and output backpressure.
        for (int t = 0; t < 24; t++) begin
            int len;
            len = (t < 6) ? (52 + 3 * t) : int'($urandom_range(1, 200));
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(255)));
            run_msg(m, 30, 60, int'($urandom_range(0, 3)), $sformatf("rand%0d_len%0d", t, len));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
